// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the IF/ID, ID/EX, EX/MEM, MEM/WB registers: load-use, multi-cycle EX, taken-branch squash.
// Optional HAZARD_STATS_EN adds a saturating StallCount of cycles with PC_Write low.
module pipeline_hazard_ctrl #(
  parameter int REG_BITS    = 5,
  parameter int MUL_LATENCY = 4
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [REG_BITS-1:0] ID_Rs,
  input  logic [REG_BITS-1:0] ID_Rt,
  input  logic                ID_UsesRt,
  input  logic                EX_MemRead,
  input  logic [REG_BITS-1:0] EX_WriteRegister,
  input  logic                EX_MulStart,
  input  logic                EX_BranchTaken,
  output logic                PC_Write,
  output logic                IFID_Write,
  output logic                IFID_Flush,
  output logic                IDEX_Write,
  output logic                IDEX_Bubble,
  output logic                EXMEM_Bubble,
  output logic                MulDone,
`ifdef HAZARD_STATS_EN
  output logic [31:0]         StallCount,
`endif
  output logic [1:0]          State
);

  localparam logic [1:0] RUN     = 2'b00;
  localparam logic [1:0] MC_BUSY = 2'b01;
  localparam logic [3:0] COUNT_INIT = 4'(MUL_LATENCY - 2);

  logic [3:0] count;
  logic [3:0] count_nxt;
  logic [1:0] state_nxt;
  logic       mul_done_nxt;
  logic       load_use;

  assign load_use = EX_MemRead && (EX_WriteRegister != '0) &&
                    ((EX_WriteRegister == ID_Rs) || (ID_UsesRt && (EX_WriteRegister == ID_Rt)));

  always_comb begin
    PC_Write     = 1'b1;
    IFID_Write   = 1'b1;
    IDEX_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Bubble  = 1'b0;
    EXMEM_Bubble = 1'b0;
    state_nxt    = RUN;
    count_nxt    = count;
    mul_done_nxt = 1'b0;
    case (State)
      MC_BUSY: begin
        // EX is frozen: every hazard input is ignored until the op drains
        PC_Write     = 1'b0;
        IFID_Write   = 1'b0;
        IDEX_Write   = 1'b0;
        EXMEM_Bubble = 1'b1;
        if (count != 4'd0) begin
          state_nxt = MC_BUSY;
          count_nxt = count - 4'd1;
        end else begin
          mul_done_nxt = 1'b1;
        end
      end
      default: begin
        if (EX_BranchTaken) begin
          IFID_Flush  = 1'b1;
          IDEX_Bubble = 1'b1;
        end else if (EX_MulStart) begin
          PC_Write     = 1'b0;
          IFID_Write   = 1'b0;
          IDEX_Write   = 1'b0;
          EXMEM_Bubble = 1'b1;
          state_nxt    = MC_BUSY;
          count_nxt    = COUNT_INIT;
        end else if (load_use) begin
          PC_Write    = 1'b0;
          IFID_Write  = 1'b0;
          IDEX_Bubble = 1'b1;
        end
      end
    endcase
    if (!Reset_n) begin
      PC_Write     = 1'b0;
      IFID_Write   = 1'b0;
      IDEX_Write   = 1'b0;
      IFID_Flush   = 1'b0;
      IDEX_Bubble  = 1'b0;
      EXMEM_Bubble = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      State   <= RUN;
      count   <= 4'd0;
      MulDone <= 1'b0;
    end else begin
      State   <= state_nxt;
      count   <= count_nxt;
      MulDone <= mul_done_nxt;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      StallCount <= 32'd0;
    end else if (!PC_Write && (StallCount != 32'hFFFF_FFFF)) begin
      StallCount <= StallCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations plus random traffic against an occupancy model.
module tb_pipeline_hazard_ctrl;
  localparam int RB  = 5;
  localparam int LAT = 4;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic [RB-1:0] ID_Rs, ID_Rt, EX_WriteRegister;
  logic          ID_UsesRt, EX_MemRead, EX_MulStart, EX_BranchTaken;
  logic          PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble, MulDone;
  logic [1:0]    State;
`ifdef HAZARD_STATS_EN
  logic [31:0]   StallCount;
`endif

  pipeline_hazard_ctrl #(.REG_BITS(RB), .MUL_LATENCY(LAT)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_WriteRegister(EX_WriteRegister), .EX_MulStart(EX_MulStart),
    .EX_BranchTaken(EX_BranchTaken), .PC_Write(PC_Write), .IFID_Write(IFID_Write),
    .IFID_Flush(IFID_Flush), .IDEX_Write(IDEX_Write), .IDEX_Bubble(IDEX_Bubble),
    .EXMEM_Bubble(EXMEM_Bubble), .MulDone(MulDone),
`ifdef HAZARD_STATS_EN
    .StallCount(StallCount),
`endif
    .State(State));

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Model state: remaining frozen-EX cycles after the current one, and the pending done pulse.
  int          m_left = 0;
  logic        m_done = 1'b0;
  int unsigned m_stalls = 0;
  logic e_pc, e_ifw, e_fl, e_idw, e_bub, e_exb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    logic lu;
    lu = EX_MemRead && EX_WriteRegister != 0 &&
         (EX_WriteRegister == ID_Rs || (ID_UsesRt && EX_WriteRegister == ID_Rt));
    if (!Reset_n) begin
      m_left = 0; m_done = 1'b0; m_stalls = 0;
      {e_pc, e_ifw, e_fl, e_idw, e_bub, e_exb} = 6'b0;
    end else if (m_left > 0) begin
      {e_pc, e_ifw, e_fl, e_idw, e_bub, e_exb} = 6'b000001;
    end else if (EX_BranchTaken) begin
      {e_pc, e_ifw, e_fl, e_idw, e_bub, e_exb} = 6'b111110;
    end else if (EX_MulStart) begin
      {e_pc, e_ifw, e_fl, e_idw, e_bub, e_exb} = 6'b000001;
    end else if (lu) begin
      {e_pc, e_ifw, e_fl, e_idw, e_bub, e_exb} = 6'b000110;
    end else begin
      {e_pc, e_ifw, e_fl, e_idw, e_bub, e_exb} = 6'b110100;
    end
  endtask

  task automatic model_check();
    model_eval();
    chk("pc_write", PC_Write, e_pc);
    chk("ifid_write", IFID_Write, e_ifw);
    chk("ifid_flush", IFID_Flush, e_fl);
    chk("idex_write", IDEX_Write, e_idw);
    chk("idex_bubble", IDEX_Bubble, e_bub);
    chk("exmem_bubble", EXMEM_Bubble, e_exb);
    chk("mul_done", MulDone, m_done);
    chk("state", State, (m_left > 0) ? 2'b01 : 2'b00);
`ifdef HAZARD_STATS_EN
    chk("stall_count", StallCount, m_stalls);
`endif
  endtask

  task automatic model_update();
    if (!Reset_n) begin
      m_left = 0; m_done = 1'b0; m_stalls = 0;
    end else begin
      if (!e_pc && m_stalls != 32'hFFFF_FFFF) m_stalls++;
      if (m_left > 0) begin
        m_left--;
        m_done = (m_left == 0);
      end else begin
        m_done = 1'b0;
        if (!EX_BranchTaken && EX_MulStart) m_left = LAT - 1;
      end
    end
  endtask

  task automatic apply(input logic [RB-1:0] rs, input logic [RB-1:0] rt, input logic ur,
                       input logic mr, input logic [RB-1:0] wr, input logic ms,
                       input logic br, input logic rn);
    @(negedge Clk);
    ID_Rs = rs; ID_Rt = rt; ID_UsesRt = ur; EX_MemRead = mr;
    EX_WriteRegister = wr; EX_MulStart = ms; EX_BranchTaken = br; Reset_n = rn;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge Clk);
    model_update();
  endtask

  initial begin
    Reset_n = 1'b1;
    {ID_Rs, ID_Rt, EX_WriteRegister} = '0;
    {ID_UsesRt, EX_MemRead, EX_MulStart, EX_BranchTaken} = '0;
    // Async reset asserted mid-cycle with busy inputs
    apply(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
    tick();
    @(negedge Clk); #2;
    Reset_n = 1'b0; #1;
    model_check();
    chk("rst_pc_lit", PC_Write, 1'b0);
    chk("rst_exmem_lit", EXMEM_Bubble, 1'b0);
    chk("rst_state_lit", State, 2'b00);
    chk("rst_done_lit", MulDone, 1'b0);
    tick();

    // Load-use on Rs, then one-cycle stall clears
    apply(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    chk("lu_pc_lit", PC_Write, 1'b0);
    chk("lu_ifid_lit", IFID_Write, 1'b0);
    chk("lu_bubble_lit", IDEX_Bubble, 1'b1);
    chk("lu_idexw_lit", IDEX_Write, 1'b1);
    tick();
    apply(5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1);
    chk("lu_release_lit", PC_Write, 1'b1);
    tick();
    apply(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("lu_reg0_lit", PC_Write, 1'b1);
    tick();
    apply(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    chk("lu_rt_unused_lit", PC_Write, 1'b1);
    tick();

    // Multi-cycle op: 4 stalled cycles, 3 in MC_BUSY, pulse on the 5th
    apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    chk("mc0_pc_lit", PC_Write, 1'b0);
    chk("mc0_state_lit", State, 2'b00);
    tick();
    for (int i = 1; i < LAT; i++) begin
      apply(5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1);
      chk("mcb_pc_lit", PC_Write, 1'b0);
      chk("mcb_exmem_lit", EXMEM_Bubble, 1'b1);
      chk("mcb_state_lit", State, 2'b01);
      chk("mcb_done_lit", MulDone, 1'b0);
      tick();
    end
    apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("mc_end_pc_lit", PC_Write, 1'b1);
    chk("mc_end_done_lit", MulDone, 1'b1);
    tick();
    apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("mc_after_done_lit", MulDone, 1'b0);
    tick();

    // Branch outranks mul start and load-use
    apply(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
    chk("br_flush_lit", IFID_Flush, 1'b1);
    chk("br_bubble_lit", IDEX_Bubble, 1'b1);
    chk("br_pc_lit", PC_Write, 1'b1);
    tick();
    apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("br_state_lit", State, 2'b00);
    tick();

    // Reset during the second MC_BUSY cycle aborts without a pulse
    apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    tick();
    apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    Reset_n = 1'b0; #1;
    model_check();
    chk("abort_state_lit", State, 2'b00);
    tick();
    apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("abort_pc_lit", PC_Write, 1'b1);
    chk("abort_done_lit", MulDone, 1'b0);
    tick();

    // Random traffic, small register range so hazards are frequent
    for (int n = 0; n < 3000; n++) begin
      apply(RB'($urandom_range(0, 3)), RB'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), RB'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 60) != 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
